// File: rtl/bht_update_queue.sv
// rtl/bht_update_queue.sv - speculative branch-outcome buffer feeding BHT updates
module bht_update_queue #(
  parameter int unsigned VLEN = 64,
  parameter type bht_update_t = struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  },
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic            resolve_valid_i,
  input  logic [VLEN-1:0] resolve_pc_i,
  input  logic            resolve_taken_i,
  output logic            resolve_ready_o,
  input  logic            commit_i,
  output bht_update_t     bht_update_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_q, cm_q, rd_q;
  logic [PW-1:0] wr_d, cm_d, rd_d;
  logic [PW-1:0] n_total, n_uncommitted, n_committed;
  logic          full, do_resolve, do_commit, do_drain;
  logic          out_valid_q, out_valid_d;
  entry_t        out_entry_q, out_entry_d;

  // Pointer differences stay correct across wrap thanks to the extra MSB.
  assign n_total       = wr_q - rd_q;
  assign n_uncommitted = wr_q - cm_q;
  assign n_committed   = cm_q - rd_q;

  assign full            = (n_total == PW'(DEPTH));
  assign resolve_ready_o = !full;

  assign do_resolve = resolve_valid_i && !full && !flush_i;
  assign do_commit  = commit_i && (n_uncommitted != '0);
  assign do_drain   = (n_committed != '0);

  always_comb begin
    wr_d        = wr_q;
    rd_d        = rd_q;
    cm_d        = cm_q + PW'(do_commit);
    out_valid_d = 1'b0;
    out_entry_d = '0;

    // Flush keeps this cycle's commit, then drops everything younger.
    if (flush_i) begin
      wr_d = cm_d;
    end else if (do_resolve) begin
      wr_d = wr_q + PW'(1);
    end

    if (do_drain) begin
      rd_d        = rd_q + PW'(1);
      out_valid_d = !debug_mode_i;
      out_entry_d = mem_q[rd_q[IW-1:0]];
    end

    if (flush_bp_i) begin
      wr_d        = '0;
      cm_d        = '0;
      rd_d        = '0;
      out_valid_d = 1'b0;
      out_entry_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q        <= '0;
      cm_q        <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
    end else begin
      wr_q        <= wr_d;
      cm_q        <= cm_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
    end
  end

  // Payload storage needs no reset; pointers define which slots are live.
  always_ff @(posedge clk_i) begin
    if (do_resolve && !flush_bp_i) begin
      mem_q[wr_q[IW-1:0]] <= '{pc: resolve_pc_i, taken: resolve_taken_i};
    end
  end

  assign bht_update_o = bht_update_t'({out_valid_q, out_entry_q});

endmodule
